// File: rtl/rmst_tile_loader_pkg.sv
// ============================================================================
// Module      : rmst_tile_loader_pkg
// Description : Shared constants, FSM states and burst helpers for the tile loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rmst_tile_loader_pkg;

  localparam int AW          = 12;
  localparam int DW          = 32;
  localparam int CW          = 8;
  localparam int XAW         = 32;
  localparam int XDW         = 128;
  localparam int WCNT        = XDW / DW;
  localparam int BURST_BYTES = 128;
  localparam int BEAT_BYTES  = XDW / 8;
  localparam int RW          = AW + 2;
  localparam int BCW         = $clog2(BURST_BYTES / BEAT_BYTES + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GO     = 3'd1,
    S_STREAM = 3'd2,
    S_NEXT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  function automatic logic [CW-1:0] burst_len(input logic [RW-1:0] rem);
    if (rem > RW'(BURST_BYTES)) return CW'(BURST_BYTES);
    return rem[CW-1:0];
  endfunction

  function automatic logic [BCW-1:0] beats_of(input logic [CW-1:0] len);
    return BCW'(len / CW'(BEAT_BYTES));
  endfunction

endpackage

`default_nettype wire

// File: rtl/rmst_tile_loader_if.sv
// ============================================================================
// Module      : rmst_tile_loader_if
// Description : Config, read-master and tile-RAM write signals of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rmst_tile_loader_if;
  import rmst_tile_loader_pkg::*;

  logic [DW-1:0]  param_raddr;
  logic [AW-1:0]  param_iolen;
  logic           config_done;
  logic           load_data_start;
  logic           load_data_done;
  logic           rmst_fixed_location;
  logic [XAW-1:0] rmst_read_base;
  logic [CW-1:0]  rmst_read_length;
  logic           rmst_go;
  logic           rmst_done;
  logic           rmst_user_read_buffer;
  logic [XDW-1:0] rmst_user_buffer_data;
  logic           rmst_user_data_available;
  logic           rmst_wr_ena;
  logic [AW-1:0]  rmst_wr_addr;
  logic [DW-1:0]  rmst_wr_data;

  // master is the loader's own view
  modport master (
    input  param_raddr, param_iolen, config_done, load_data_start,
    input  rmst_done, rmst_user_buffer_data, rmst_user_data_available,
    output load_data_done, rmst_fixed_location, rmst_read_base, rmst_read_length,
    output rmst_go, rmst_user_read_buffer, rmst_wr_ena, rmst_wr_addr, rmst_wr_data
  );

  modport slave (
    output param_raddr, param_iolen, config_done, load_data_start,
    output rmst_done, rmst_user_buffer_data, rmst_user_data_available,
    input  load_data_done, rmst_fixed_location, rmst_read_base, rmst_read_length,
    input  rmst_go, rmst_user_read_buffer, rmst_wr_ena, rmst_wr_addr, rmst_wr_data
  );

endinterface

`default_nettype wire

// File: rtl/rmst_tile_loader_beat_unpacker.sv
// ============================================================================
// Module      : rmst_tile_loader_beat_unpacker
// Description : Splits each popped beat into WCNT sequential tile-RAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rmst_tile_loader_beat_unpacker
  import rmst_tile_loader_pkg::*;
(
  input  wire logic           clk,
  input  wire logic           rst,
  input  wire logic           i_clear,
  input  wire logic           i_pop,
  input  wire logic [XDW-1:0] i_beat,
  output logic                o_busy,
  output logic                o_wr_ena,
  output logic [AW-1:0]       o_wr_addr,
  output logic [DW-1:0]       o_wr_data
);

  localparam int IW = $clog2(WCNT);

  logic [XDW-1:0] r_beat;
  logic [IW-1:0]  r_idx;
  logic           r_busy;
  logic           r_wr_ena;
  logic [AW-1:0]  r_next_addr;
  logic [AW-1:0]  r_wr_addr;
  logic [DW-1:0]  r_wr_data;

  // Word 0 is written straight from the incoming beat, so busy drops during
  // the last word's write cycle and the next pop can overlap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat      <= '0;
      r_idx       <= '0;
      r_busy      <= 1'b0;
      r_wr_ena    <= 1'b0;
      r_next_addr <= '0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_ena <= 1'b0;
      if (i_clear) r_next_addr <= '0;
      if (i_pop) begin
        r_beat      <= i_beat;
        r_idx       <= IW'(1);
        r_busy      <= 1'b1;
        r_wr_ena    <= 1'b1;
        r_wr_data   <= i_beat[DW-1:0];
        r_wr_addr   <= r_next_addr;
        r_next_addr <= r_next_addr + 1'b1;
      end else if (r_busy) begin
        r_wr_ena    <= 1'b1;
        r_wr_data   <= r_beat[int'(r_idx)*DW +: DW];
        r_wr_addr   <= r_next_addr;
        r_next_addr <= r_next_addr + 1'b1;
        r_idx       <= r_idx + 1'b1;
        if (r_idx == IW'(WCNT-1)) r_busy <= 1'b0;
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_wr_ena  = r_wr_ena;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: rtl/rmst_tile_loader.sv
// ============================================================================
// Module      : rmst_tile_loader
// Description : Bursts a tile from external memory into the tile RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rmst_tile_loader
  import rmst_tile_loader_pkg::*;
(
  input  wire logic          clk,
  input  wire logic          rst,
  rmst_tile_loader_if.master bus
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [DW-1:0]  r_raddr;
  logic [AW-1:0]  r_iolen;
  logic [XAW-1:0] r_base;
  logic [CW-1:0]  r_len;
  logic [RW-1:0]  r_rem;
  logic [BCW-1:0] r_beats_left;
  logic           r_done_seen;
  logic           r_go;
  logic           r_load_done;
  logic [RW-1:0]  w_total;
  logic [RW-1:0]  w_rem_after;
  logic           w_pop;
  logic           w_busy;
  logic           w_clear;
  logic           w_stream_end;
  logic           w_wr_ena;
  logic [AW-1:0]  w_wr_addr;
  logic [DW-1:0]  w_wr_data;

  // Partial beats at the tail of the tile are dropped.
  assign w_total      = RW'(r_iolen / AW'(WCNT)) * RW'(BEAT_BYTES);
  assign w_rem_after  = r_rem - RW'(r_len);
  assign w_pop        = (r_state == S_STREAM) && bus.rmst_user_data_available &&
                        !w_busy && (r_beats_left != '0);
  assign w_stream_end = (r_beats_left == '0) && !w_busy && (r_done_seen || bus.rmst_done);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.load_data_start) begin
          w_clear     = 1'b1;
          w_state_nxt = (w_total == '0) ? S_DONE : S_GO;
        end
      end
      S_GO:     w_state_nxt = S_STREAM;
      S_STREAM: if (w_stream_end) w_state_nxt = S_NEXT;
      S_NEXT:   w_state_nxt = (w_rem_after != '0) ? S_GO : S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr      <= '0;
      r_iolen      <= '0;
      r_base       <= '0;
      r_len        <= '0;
      r_rem        <= '0;
      r_beats_left <= '0;
      r_done_seen  <= 1'b0;
      r_go         <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_go        <= (w_state_nxt == S_GO);
      r_load_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.config_done) begin
            r_raddr <= bus.param_raddr;
            r_iolen <= bus.param_iolen;
          end
          if (bus.load_data_start) begin
            r_base       <= XAW'(r_raddr);
            r_rem        <= w_total;
            r_len        <= burst_len(w_total);
            r_beats_left <= beats_of(burst_len(w_total));
            r_done_seen  <= 1'b0;
          end
        end
        S_STREAM: begin
          // The read master may finish before its beats are drained.
          if (bus.rmst_done) r_done_seen <= 1'b1;
          if (w_pop) r_beats_left <= r_beats_left - 1'b1;
        end
        S_NEXT: begin
          r_base       <= r_base + XAW'(r_len);
          r_rem        <= w_rem_after;
          r_len        <= burst_len(w_rem_after);
          r_beats_left <= beats_of(burst_len(w_rem_after));
          r_done_seen  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  rmst_tile_loader_beat_unpacker u_unpack (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_pop     (w_pop),
    .i_beat    (bus.rmst_user_buffer_data),
    .o_busy    (w_busy),
    .o_wr_ena  (w_wr_ena),
    .o_wr_addr (w_wr_addr),
    .o_wr_data (w_wr_data)
  );

  assign bus.load_data_done        = r_load_done;
  assign bus.rmst_fixed_location   = 1'b0;
  assign bus.rmst_read_base        = r_base;
  assign bus.rmst_read_length      = r_len;
  assign bus.rmst_go               = r_go;
  assign bus.rmst_user_read_buffer = w_pop;
  assign bus.rmst_wr_ena           = w_wr_ena;
  assign bus.rmst_wr_addr          = w_wr_addr;
  assign bus.rmst_wr_data          = w_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_rmst_tile_loader.sv
// ============================================================================
// Module      : tb_rmst_tile_loader
// Description : Self-checking bench with a read-master/memory model and tile RAM shadow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rmst_tile_loader;
  import rmst_tile_loader_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rmst_tile_loader_if bus ();
  rmst_tile_loader dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  int wr_cnt, done_cnt, go_cnt, pop_cnt, last_addr, exp_words, stall;
  logic [31:0] exp_raddr, last_base;
  logic [31:0] exp_base_q[$];
  logic [7:0]  exp_len_q[$];
  logic [7:0]  seen_len[$];
  logic [31:0] tb_ram [0:4095];
  bit          early_mode;
  logic [127:0] q[$];
  int          push_left, lat;
  logic [31:0] push_w;
  bit          burst_act;
  logic        pop_edge;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Pop as seen by the DUT at the edge, for the memory model to retire.
  always @(posedge clk) begin
    pop_edge <= bus.rmst_user_read_buffer;
    if (bus.rmst_user_read_buffer) pop_cnt <= pop_cnt + 1;
  end

  // Read-master model, burst plan check and tile-RAM write check.
  always @(negedge clk) begin
    logic [31:0] eb;
    logic [7:0]  el;
    if (rst) begin
      q.delete();
      push_left = 0;
      lat = 0;
      burst_act = 0;
      bus.rmst_done = 1'b0;
      bus.rmst_user_data_available = 1'b0;
      bus.rmst_user_buffer_data = '0;
    end else begin
      if (pop_edge) begin
        chk("pop_q_nonempty", q.size() > 0, 1);
        if (q.size() > 0) void'(q.pop_front());
      end
      bus.rmst_done = 1'b0;
      if (burst_act && push_left == 0 && (early_mode || q.size() == 0)) begin
        bus.rmst_done = 1'b1;
        burst_act = 0;
      end
      if (bus.rmst_go) begin
        go_cnt++;
        chk("go_in_plan", exp_base_q.size() > 0, 1);
        if (exp_base_q.size() > 0) begin
          eb = exp_base_q.pop_front();
          el = exp_len_q.pop_front();
          chk("burst_base", bus.rmst_read_base, eb);
          chk("burst_len", bus.rmst_read_length, el);
          chk("go_after_drain", wr_cnt, (eb - exp_raddr) / 4);
        end
        seen_len.push_back(bus.rmst_read_length);
        last_base = bus.rmst_read_base;
        push_left = int'(bus.rmst_read_length) / 16;
        push_w = bus.rmst_read_base / 4;
        lat = 3;
        burst_act = 1;
      end
      if (lat > 0) lat--;
      else if (push_left > 0) begin
        q.push_back({push_w + 32'd3, push_w + 32'd2, push_w + 32'd1, push_w});
        push_w += 4;
        push_left--;
      end
      bus.rmst_user_data_available = (q.size() > 0) && (stall == 0);
      bus.rmst_user_buffer_data = (q.size() > 0) ? q[0] : '0;
      if (stall > 0) stall--;
      if (bus.rmst_wr_ena) begin
        chk("wr_addr", bus.rmst_wr_addr, wr_cnt % 4096);
        chk("wr_data", bus.rmst_wr_data, exp_raddr / 4 + wr_cnt);
        tb_ram[bus.rmst_wr_addr] = bus.rmst_wr_data;
        last_addr = int'(bus.rmst_wr_addr);
        wr_cnt++;
      end
      if (bus.load_data_done) begin
        done_cnt++;
        chk("done_word_count", wr_cnt, exp_words);
        chk("done_all_bursts", exp_base_q.size(), 0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setup(input logic [31:0] raddr, input int iolen, input bit early);
    int rem;
    logic [31:0] b;
    exp_raddr = raddr;
    exp_words = (iolen / 4) * 4;
    wr_cnt = 0; done_cnt = 0; go_cnt = 0;
    early_mode = early;
    exp_base_q.delete(); exp_len_q.delete(); seen_len.delete();
    rem = exp_words * 4;
    b = raddr;
    while (rem > 0) begin
      exp_base_q.push_back(b);
      exp_len_q.push_back((rem > 128) ? 8'd128 : 8'(rem));
      b += 128;
      rem = (rem > 128) ? rem - 128 : 0;
    end
    for (int i = 0; i < 4096; i++) tb_ram[i] = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.param_raddr = raddr;
    bus.param_iolen = 12'(iolen);
    bus.config_done = 1'b1;
    @(negedge clk);
    bus.config_done = 1'b0;
  endtask

  task automatic start_and_wait(output int go_lat, output int done_lat);
    go_lat = -1;
    done_lat = -1;
    bus.load_data_start = 1'b1;
    for (int c = 1; c <= 20000 && done_lat < 0; c++) begin
      @(negedge clk);
      bus.load_data_start = 1'b0;
      if (bus.rmst_go && go_lat < 0) go_lat = c;
      if (bus.load_data_done) done_lat = c;
    end
    chk("done_seen_in_time", done_lat > 0, 1);
    cyc(4);
    chk("single_done", done_cnt, 1);
  endtask

  task automatic check_ram();
    int bad = 0;
    for (int i = 0; i < exp_words; i++)
      if (tb_ram[i] !== exp_raddr / 4 + i) bad++;
    chk("ram_contents", bad, 0);
  endtask

  task automatic check_idle_outputs(input string p);
    chk({p, "_go"}, bus.rmst_go, 0);
    chk({p, "_pop"}, bus.rmst_user_read_buffer, 0);
    chk({p, "_wr_ena"}, bus.rmst_wr_ena, 0);
    chk({p, "_wr_addr"}, bus.rmst_wr_addr, 0);
    chk({p, "_wr_data"}, bus.rmst_wr_data, 0);
    chk({p, "_done"}, bus.load_data_done, 0);
    chk({p, "_base"}, bus.rmst_read_base, 0);
    chk({p, "_len"}, bus.rmst_read_length, 0);
    chk({p, "_fixed"}, bus.rmst_fixed_location, 0);
  endtask

  initial begin
    int gl, dl, p0, w0, guard;
    bus.param_raddr = '0;
    bus.param_iolen = '0;
    bus.config_done = 1'b0;
    bus.load_data_start = 1'b0;
    stall = 0;
    early_mode = 0;
    pop_cnt = 0;
    cyc(3);
    check_idle_outputs("reset");
    rst = 1'b0;
    cyc(2);

    // Full tile, 32 bursts of 128 bytes.
    setup(32'h0, 1024, 0);
    start_and_wait(gl, dl);
    chk("go_latency", gl, 1);
    chk("t1_burst_count", go_cnt, 32);
    chk("t1_last_base", last_base, 3968);
    chk("t1_last_addr", last_addr, 1023);
    check_ram();

    // Short tile with a partial final burst.
    setup(32'h100, 40, 0);
    start_and_wait(gl, dl);
    chk("t2_burst_count", go_cnt, 2);
    chk("t2_len0", seen_len[0], 128);
    chk("t2_len1", seen_len[1], 32);
    chk("t2_last_addr", last_addr, 39);
    check_ram();

    // Empty tile.
    setup(32'h40, 0, 0);
    start_and_wait(gl, dl);
    chk("t3_done_latency", dl, 2);
    chk("t3_no_go", go_cnt, 0);
    chk("t3_no_writes", wr_cnt, 0);

    // Data starvation mid-burst.
    setup(32'h0, 256, 0);
    fork
      start_and_wait(gl, dl);
      begin
        guard = 0;
        while (wr_cnt < 100 && guard < 5000) begin @(negedge clk); guard++; end
        chk("t4_reached_stall_point", wr_cnt >= 100, 1);
        stall = 20;
        cyc(2);
        p0 = pop_cnt;
        cyc(4);
        w0 = wr_cnt;
        cyc(13);
        chk("t4_stall_no_pop", pop_cnt, p0);
        chk("t4_stall_no_write", wr_cnt, w0);
      end
    join
    check_ram();

    // Read master reports done before its beats are consumed.
    setup(32'h0, 64, 1);
    start_and_wait(gl, dl);
    chk("t5_burst_count", go_cnt, 2);
    check_ram();
    early_mode = 0;

    // Reset during streaming, then a clean reload.
    setup(32'h0, 1024, 0);
    bus.load_data_start = 1'b1;
    cyc(1);
    bus.load_data_start = 1'b0;
    guard = 0;
    while (wr_cnt < 50 && guard < 5000) begin @(negedge clk); guard++; end
    chk("t6_reached_reset_point", wr_cnt >= 50, 1);
    rst = 1'b1;
    cyc(1);
    check_idle_outputs("t6_rst");
    cyc(1);
    rst = 1'b0;
    cyc(2);
    chk("t6_no_done_on_abort", done_cnt, 0);
    setup(32'h0, 1024, 0);
    start_and_wait(gl, dl);
    chk("t6_burst_count", go_cnt, 32);
    check_ram();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
